// File: rtl/gcd_display_pkg.sv
// Shared definitions for the GCD result display path: converter FSM state
// encoding and a sizing helper for the BCD digit count.
package gcd_display_pkg;

    // Converter FSM state, kept as plain vector constants for older flows.
    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Minimum number of decimal digits needed to show any value of an
    // unsigned binary word of the given width: ceil(width * log10(2)).
    // width * log10(2) is never an exact integer for width > 0, so the
    // fixed-point ceiling below is exact for any practical width.
    function automatic int min_bcd_digits(input int bin_width);
        int digits;
        digits = (bin_width * 32'sd30103 + 32'sd99999) / 32'sd100000;
        if (digits < 32'sd1) begin
            digits = 32'sd1;
        end
        return digits;
    endfunction

endpackage : gcd_display_pkg

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
// The result never exceeds 12, so no carry out of the nibble exists.
module bcd_add3_nibble (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional +3 correction of one BCD digit.
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule : bcd_add3_nibble

// File: rtl/bin_to_bcd_converter.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per clock).
// A conversion takes BIN_WIDTH cycles; results, leading-zero mask and the
// overflow flag are registered and held until the next completion.
module bin_to_bcd_converter
    import gcd_display_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = min_bcd_digits(BIN_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   bin_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic [DIGITS-1:0]      digit_valid,
    output logic                   overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(BIN_WIDTH - 1);
    localparam logic [DIGITS-1:0] VALID_RESET = DIGITS'(1);

    // Leading-zero mask: digit i is significant when it or any more
    // significant digit is nonzero; the units digit always shows.
    function automatic logic [DIGITS-1:0] significant_mask(input logic [BCD_W-1:0] bcd);
        logic [DIGITS-1:0] mask;
        logic              seen;
        mask = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            mask[i] = seen;
        end
        mask[0] = 1'b1;
        return mask;
    endfunction

    // Control state
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 busy_r;

    // Conversion datapath
    logic [BIN_WIDTH-1:0] shift_r;
    logic [BCD_W-1:0]     scratch_r;
    logic                 ovf_sticky_r;

    // Published results
    logic                 done_r;
    logic [BCD_W-1:0]     bcd_r;
    logic [DIGITS-1:0]    valid_r;
    logic                 ovf_r;

    // Combinational next-iteration values
    logic [BCD_W-1:0]     corr_s;
    logic [BCD_W-1:0]     next_scratch_s;
    logic [BIN_WIDTH-1:0] next_shift_s;
    logic                 next_ovf_s;
    logic                 last_iter_s;
    logic                 accept_s;

    // One correction cell per digit; nibbles never carry into each other.
    for (genvar g = 0; g < DIGITS; g++) begin : g_nibble
        bcd_add3_nibble u_add3 (
            .din  (scratch_r[4*g +: 4]),
            .dout (corr_s[4*g +: 4])
        );
    end

    // One double-dabble step: corrected scratch and binary shift left
    // together, the binary MSB enters the units digit, and a bit leaving the
    // top digit marks the value as too large for DIGITS digits.
    always_comb begin
        next_scratch_s = {corr_s[BCD_W-2:0], shift_r[BIN_WIDTH-1]};
        next_shift_s   = {shift_r[BIN_WIDTH-2:0], 1'b0};
        next_ovf_s     = ovf_sticky_r | corr_s[BCD_W-1];
        last_iter_s    = (cnt_r == LAST_CNT);
        accept_s       = (state_r == ST_IDLE) && start;
    end

    // FSM, iteration counter and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_SHIFT;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_iter_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_SHIFT;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Shift register, scratch digits and sticky overflow. bin_in is only
    // looked at on an accepted start, so later changes cannot disturb a run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r      <= '0;
            scratch_r    <= '0;
            ovf_sticky_r <= 1'b0;
        end else begin
            if (accept_s) begin
                shift_r      <= bin_in;
                scratch_r    <= '0;
                ovf_sticky_r <= 1'b0;
            end else if (state_r == ST_SHIFT) begin
                shift_r      <= next_shift_s;
                scratch_r    <= next_scratch_s;
                ovf_sticky_r <= next_ovf_s;
            end else begin
                shift_r      <= shift_r;
                scratch_r    <= scratch_r;
                ovf_sticky_r <= ovf_sticky_r;
            end
        end
    end

    // Result registers: updated with a one-cycle done pulse on the edge that
    // performs the final iteration, otherwise holding the previous result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_r  <= 1'b0;
            bcd_r   <= '0;
            valid_r <= VALID_RESET;
            ovf_r   <= 1'b0;
        end else begin
            if ((state_r == ST_SHIFT) && last_iter_s) begin
                done_r  <= 1'b1;
                bcd_r   <= next_scratch_s;
                valid_r <= significant_mask(next_scratch_s);
                ovf_r   <= next_ovf_s;
            end else begin
                done_r  <= 1'b0;
                bcd_r   <= bcd_r;
                valid_r <= valid_r;
                ovf_r   <= ovf_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign bcd_out     = bcd_r;
    assign digit_valid = valid_r;
    assign overflow    = ovf_r;

endmodule : bin_to_bcd_converter

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter. Two instances share the
// stimulus: the full-range 5-digit build and a 4-digit build that exercises
// overflow. Expected values come from decimal arithmetic on the input value.
module tb_bin_to_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;

    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic [4:0]  dv5;

    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  dv4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_converter #(.BIN_WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy5), .done(done5), .bcd_out(bcd5),
        .digit_valid(dv5), .overflow(ovf5)
    );

    bin_to_bcd_converter #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy4), .done(done4), .bcd_out(bcd4),
        .digit_valid(dv4), .overflow(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---- reference model: plain decimal arithmetic ----
    function automatic int unsigned pow10(input int d);
        int unsigned p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] ref_bcd(input int unsigned v, input int d);
        logic [31:0] r = '0;
        int unsigned t = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_valid(input int unsigned v, input int d);
        int unsigned m = v % pow10(d);
        int n = 1;
        while (m >= 10) begin
            m = m / 10;
            n++;
        end
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic logic [31:0] ref_ovf(input int unsigned v, input int d);
        return (v >= pow10(d)) ? 32'd1 : 32'd0;
    endfunction

    task automatic check_result(input string tag, input int unsigned v);
        check({tag, "_bcd5"},  32'(bcd5), ref_bcd(v, 5));
        check({tag, "_dv5"},   32'(dv5),  ref_valid(v, 5));
        check({tag, "_ovf5"},  32'(ovf5), ref_ovf(v, 5));
        check({tag, "_bcd4"},  32'(bcd4), ref_bcd(v, 4));
        check({tag, "_dv4"},   32'(dv4),  ref_valid(v, 4));
        check({tag, "_ovf4"},  32'(ovf4), ref_ovf(v, 4));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(busy5), 32'd0);
        check({tag, "_done"}, 32'(done5), 32'd0);
        check({tag, "_bcd5"}, 32'(bcd5),  32'd0);
        check({tag, "_dv5"},  32'(dv5),   32'd1);
        check({tag, "_ovf5"}, 32'(ovf5),  32'd0);
        check({tag, "_bcd4"}, 32'(bcd4),  32'd0);
        check({tag, "_dv4"},  32'(dv4),   32'd1);
    endtask

    // Present start for one cycle at a falling edge; afterwards scramble
    // bin_in to show it no longer matters.
    task automatic start_conv(input logic [15:0] v);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'($urandom);
    endtask

    // Wait (bounded) for done, counting busy cycles; optionally pulse an
    // extra start while busy (poke_at = busy cycle number, 0 = none).
    task automatic finish_conv(input string tag, input int unsigned v,
                               input int poke_at, input logic [15:0] poke_val);
        int busy_cycles = 0;
        int guard = 0;
        while (done5 !== 1'b1 && guard < 40) begin
            if (busy5 === 1'b1) busy_cycles++;
            if (busy_cycles == poke_at) begin
                start  = 1'b1;
                bin_in = poke_val;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check({tag, "_done_seen"},   32'(done5), 32'd1);
        check({tag, "_done4"},       32'(done4), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
        check({tag, "_busy_at_done"}, 32'(busy5), 32'd0);
        check_result(tag, v);
    endtask

    initial begin
        int seen;
        int unsigned v;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 16'd0;

        // Reset held for three cycles, then idle with no start.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset("reset");
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done5 !== 1'b0 || busy5 !== 1'b0 || done4 !== 1'b0) seen++;
        end
        check("idle_quiet", 32'(seen), 32'd0);
        check_reset("idle");

        // Basic conversion with latency and single-cycle done.
        start_conv(16'd1234);
        finish_conv("c1234", 1234, 0, 16'd0);
        @(negedge clk);
        check("c1234_done_pulse", 32'(done5), 32'd0);
        check("c1234_hold", 32'(bcd5), 32'h01234);

        // Range extremes.
        start_conv(16'd0);
        finish_conv("c0", 0, 0, 16'd0);
        @(negedge clk);
        start_conv(16'd65535);
        finish_conv("c65535", 65535, 0, 16'd0);
        @(negedge clk);

        // Ignored mid-busy start, then back-to-back start in the done cycle.
        start_conv(16'd42);
        finish_conv("b2b42", 42, 5, 16'd999);
        start_conv(16'd7);
        check("b2b_done_drop", 32'(done5), 32'd0);
        check("b2b_busy_again", 32'(busy5), 32'd1);
        check("b2b_hold42", 32'(bcd5), 32'h00042);
        finish_conv("b2b7", 7, 0, 16'd0);
        @(negedge clk);

        // Reset on the 8th cycle of a conversion: aborted, no done.
        start_conv(16'd9999);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        rst_n = 1'b1;
        seen = 0;
        repeat (24) begin
            @(negedge clk);
            if (done5 !== 1'b0 || busy5 !== 1'b0) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        start_conv(16'd9999);
        finish_conv("c9999", 9999, 0, 16'd0);
        @(negedge clk);

        // Overflow boundaries for the 4-digit instance.
        start_conv(16'd12345);
        finish_conv("c12345", 12345, 0, 16'd0);
        @(negedge clk);
        start_conv(16'd10000);
        finish_conv("c10000", 10000, 0, 16'd0);
        @(negedge clk);

        // Randomized values, random ignored starts, occasional back-to-back.
        for (int n = 0; n < 16; n++) begin
            v = $urandom_range(0, 65535);
            start_conv(16'(v));
            finish_conv("rand", v, $urandom_range(0, 15), 16'($urandom));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bin_to_bcd_converter

// File: doc/bin_to_bcd_converter.md
# bin_to_bcd_converter

Sequential binary-to-BCD converter that sits directly upstream of the per-digit seven-segment decoders. It takes an unsigned binary result (e.g. the GCD output), converts it with an iterative shift-add-3 (double-dabble) algorithm one bit per clock, and presents a packed array of 4-bit decimal digits plus a leading-zero mask. The display path consumes these values, one nibble per decoder.

## Interface

- BIN_WIDTH, 16, width of the unsigned binary input
- DIGITS, 5, number of BCD digits produced; the full-range value is ceil(BIN_WIDTH·log10 2)
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request a conversion; sampled only in IDLE
- bin_in  input  BIN_WIDTH  value to convert; latched on the accepted start
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse when bcd_out/digit_valid/overflow update
- bcd_out  output  4·DIGITS  packed digits, digit 0 (units) in bits [3:0]
- digit_valid  output  DIGITS  1 = digit is significant (not a leading zero); bit 0 always 1
- overflow  output  1  result did not fit in DIGITS digits; valid with done, held until next done

## Operation

- FSM states: IDLE, SHIFT.
- IDLE, start=1: latch bin_in into shift register, clear scratch BCD register and sticky overflow, bit counter=0, go to SHIFT.
- IDLE, start=0: hold.
- SHIFT, one iteration per cycle:
  - every scratch nibble ≥5 gets +3;
  - the {scratch, shift} register shifts left by 1; the binary MSB enters scratch bit 0;
  - a 1 shifted out of the top scratch nibble sets sticky overflow.
- After iteration BIN_WIDTH, on the same edge:
  - copy scratch to bcd_out;
  - compute digit_valid: bit i=1 if any digit j≥i is nonzero; bit 0 forced 1;
  - register overflow, pulse done, return to IDLE.
- start while busy is ignored; bin_in changes after acceptance have no effect.
- Outputs hold the last completed result until the next completion.
- All arithmetic is unsigned. Nibble correction is a 4-bit add with no carry between nibbles, since a corrected nibble is ≤12.
- Reset values: busy=0, done=0, bcd_out=0, digit_valid=1 (bit 0 only), overflow=0, state IDLE.

## Timing

- start sampled high at edge k: busy=1 from edge k through edge k+BIN_WIDTH.
- Edge k+BIN_WIDTH: busy→0, done→1, outputs updated. Latency is BIN_WIDTH cycles from start sample to done.
- done is high for exactly one cycle.
- Back-to-back: start sampled in the cycle where done=1 is accepted (FSM is in IDLE). Throughput is one conversion per BIN_WIDTH cycles.
- rst_n low at any edge, including mid-conversion:
  - the conversion is aborted and all outputs return to reset values;
  - no done is generated for the aborted conversion.
- rst_n has priority over start on the same edge.

## Structure

- Shared package gcd_display_pkg holds:
  - the FSM state typedef (IDLE, SHIFT);
  - a constant function computing the minimum digit count for a binary width.
- Sub-module bcd_add3_nibble: combinational 4-bit in/out, adds 3 when input ≥5. Instantiated DIGITS times via generate.
- Counter width: clog2(BIN_WIDTH+1).

## Test plan

- Reset then idle, rst_n held low 3 cycles then released, start=0 -> bcd_out=0, digit_valid=5'b00001, busy=0, done never asserted.
- Conversion and latency, bin_in=1234 with a one-cycle start -> busy exactly 16 cycles, done one cycle later-edge aligned, bcd_out=20'h01234, digit_valid=5'b01111, overflow=0.
- Range extremes:
  - bin_in=0 -> bcd_out=20'h00000, digit_valid=5'b00001;
  - bin_in=65535 -> bcd_out=20'h65535, digit_valid=5'b11111.
- Back-to-back and ignored start:
  - 42 is converted, and start is pulsed again during busy with bin_in=999 -> the mid-busy start is ignored, result 20'h00042;
  - start with 7 in the done cycle -> second done after 16 cycles, bcd_out=20'h00007.
- Reset mid-conversion, rst_n low at cycle 8 of a conversion of 9999 -> no done, outputs at reset values; a fresh start with 9999 -> 20'h09999.
- Overflow, with DIGITS=4 and BIN_WIDTH=16:
  - 12345 -> overflow=1, bcd_out=16'h2345;
  - 9999 -> overflow=0, bcd_out=16'h9999.
